// File: rtl/mipi_lp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mipi_lp_pkg
// Description : Shared LP line codes and per-lane state encoding for the
//               MIPI D-PHY LP lane-state detector.
// Revision    : 1.0 - initial release
// ============================================================================
package mipi_lp_pkg;

   // LP pair codes, {Dp,Dn}
   localparam logic [1:0] LP00 = 2'b00;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP10 = 2'b10;
   localparam logic [1:0] LP11 = 2'b11;

   typedef enum logic [3:0] {
      ST_STOP     = 4'd0,
      ST_HS_RQST  = 4'd1,
      ST_HS_PRPR  = 4'd2,
      ST_HS_BURST = 4'd3,
      ST_ESC_RQST = 4'd4,
      ST_ESC_GO   = 4'd5,
      ST_ESC_CONF = 4'd6,
      ST_ESC_MODE = 4'd7,
      ST_ERR      = 4'd8
   } lane_state_e;

endpackage
`default_nettype wire

// File: rtl/mipi_lp_lane_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mipi_lp_lane_fsm
// Description : One lane: LP synchroniser, stability filter, dwell counter
//               and HS/escape entry state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_lp_lane_fsm
   import mipi_lp_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int GLITCH_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [1:0] lp_i,
   output logic       hs_burst_o,
   output logic       hs_start_o,
   output logic       hs_end_o,
   output logic       esc_entry_o,
   output logic       err_o,
   output logic [3:0] state_o
);

   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_gl_w  = $clog2(GLITCH_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_timeout     = c_cnt_w'(TIMEOUT_CYCLES);
   localparam logic [c_gl_w-1:0]  c_glitch      = c_gl_w'(GLITCH_CYCLES);

   logic [1:0]         r_sync1, r_sync2, r_sync_d, r_lp_f;
   logic [c_gl_w-1:0]  r_run, w_run;
   logic [c_cnt_w-1:0] r_cnt;
   lane_state_e        r_state, w_next;
   logic               w_timeout;
   logic               w_hs_start, w_hs_end, w_esc_entry, w_err;
   logic               r_hs_burst, r_hs_start, r_hs_end, r_esc_entry, r_err;

   // w_run = consecutive cycles the synchronised value has held, saturating
   always_comb begin
      w_run = r_run;
      if (r_sync2 != r_sync_d) begin
         w_run = c_gl_w'(1);
      end else if (r_run < c_glitch) begin
         w_run = r_run + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_sync1  <= LP11;
         r_sync2  <= LP11;
         r_sync_d <= LP11;
         r_lp_f   <= LP11;
         r_run    <= '0;
      end else begin
         r_sync1  <= lp_i;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
         r_run    <= w_run;
         if (w_run >= c_glitch) begin
            r_lp_f <= r_sync2;
         end
      end
   end

   // State, dwell counter and registered event pulses
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state     <= ST_STOP;
         r_cnt       <= '0;
         r_hs_burst  <= 1'b0;
         r_hs_start  <= 1'b0;
         r_hs_end    <= 1'b0;
         r_esc_entry <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (r_cnt < c_timeout) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_hs_burst  <= (w_next == ST_HS_BURST);
         r_hs_start  <= w_hs_start;
         r_hs_end    <= w_hs_end;
         r_esc_entry <= w_esc_entry;
         r_err       <= w_err;
      end
   end

   assign w_timeout = (r_cnt >= c_timeout);

   // Decoded lp_f transitions are listed before the timeout so they win
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_STOP: begin
            if (r_lp_f == LP01)      w_next = ST_HS_RQST;
            else if (r_lp_f == LP10) w_next = ST_ESC_RQST;
            else if (r_lp_f == LP00) w_next = ST_ERR;
         end
         ST_HS_RQST: begin
            if (r_lp_f == LP00)      w_next = ST_HS_PRPR;
            else if (r_lp_f == LP11) w_next = ST_STOP;
            else if (r_lp_f == LP10) w_next = ST_ERR;
            else if (w_timeout)      w_next = ST_ERR;
         end
         ST_HS_PRPR: begin
            if (r_lp_f == LP11)              w_next = ST_STOP;
            else if (r_cnt == c_settle_last) w_next = ST_HS_BURST;
         end
         ST_HS_BURST: begin
            if (r_lp_f == LP11) w_next = ST_STOP;
         end
         ST_ESC_RQST: begin
            if (r_lp_f == LP00)      w_next = ST_ESC_GO;
            else if (r_lp_f == LP11) w_next = ST_STOP;
            else if (r_lp_f == LP01) w_next = ST_ERR;
            else if (w_timeout)      w_next = ST_ERR;
         end
         ST_ESC_GO: begin
            if (r_lp_f == LP01)      w_next = ST_ESC_CONF;
            else if (r_lp_f == LP11) w_next = ST_STOP;
            else if (r_lp_f == LP10) w_next = ST_ERR;
            else if (w_timeout)      w_next = ST_ERR;
         end
         ST_ESC_CONF: begin
            if (r_lp_f == LP00)      w_next = ST_ESC_MODE;
            else if (r_lp_f == LP11) w_next = ST_STOP;
            else if (r_lp_f == LP10) w_next = ST_ERR;
            else if (w_timeout)      w_next = ST_ERR;
         end
         ST_ESC_MODE, ST_ERR: begin
            if (r_lp_f == LP11) w_next = ST_STOP;
         end
         default: w_next = ST_STOP;
      endcase
   end

   always_comb begin
      w_hs_start  = (w_next == ST_HS_BURST) && (r_state != ST_HS_BURST);
      w_hs_end    = (r_state == ST_HS_BURST) && (w_next == ST_STOP);
      w_esc_entry = (w_next == ST_ESC_MODE) && (r_state != ST_ESC_MODE);
      w_err       = (w_next == ST_ERR) && (r_state != ST_ERR);
   end

   assign hs_burst_o  = r_hs_burst;
   assign hs_start_o  = r_hs_start;
   assign hs_end_o    = r_hs_end;
   assign esc_entry_o = r_esc_entry;
   assign err_o       = r_err;
   assign state_o     = r_state;

endmodule
`default_nettype wire

// File: rtl/mipi_lp_lane_state_detector.sv
`default_nettype none
// ============================================================================
// Module      : mipi_lp_lane_state_detector
// Description : Multi-lane MIPI D-PHY LP line-state detector; one independent
//               lane FSM per data lane plus an all-lanes-in-HS flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_lp_lane_state_detector
   import mipi_lp_pkg::*;
#(
   parameter int LANES          = 1,
   parameter int SETTLE_CYCLES  = 4,
   parameter int GLITCH_CYCLES  = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [2*LANES-1:0]   lp_i,
   output logic [LANES-1:0]     hs_burst_o,
   output logic [LANES-1:0]     hs_start_o,
   output logic [LANES-1:0]     hs_end_o,
   output logic [LANES-1:0]     esc_entry_o,
   output logic [LANES-1:0]     err_o,
   output logic [4*LANES-1:0]   state_o,
   output logic                 all_hs_o
);

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      mipi_lp_lane_fsm #(
         .SETTLE_CYCLES  (SETTLE_CYCLES),
         .GLITCH_CYCLES  (GLITCH_CYCLES),
         .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_lane (
         .sys_clk     (sys_clk),
         .sys_rst     (sys_rst),
         .lp_i        (lp_i[2*n+1:2*n]),
         .hs_burst_o  (hs_burst_o[n]),
         .hs_start_o  (hs_start_o[n]),
         .hs_end_o    (hs_end_o[n]),
         .esc_entry_o (esc_entry_o[n]),
         .err_o       (err_o[n]),
         .state_o     (state_o[4*n+3:4*n])
      );
   end

   assign all_hs_o = &hs_burst_o;

endmodule
`default_nettype wire

// File: tb/tb_mipi_lp_lane_state_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mipi_lp_lane_state_detector
// Description : Directed self-checking bench for the LP lane-state detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mipi_lp_lane_state_detector;

   localparam int LANES   = 2;
   localparam int SETTLE  = 4;
   localparam int GLITCH  = 2;
   localparam int TIMEOUT = 64;

   logic               sys_clk = 1'b0;
   logic               sys_rst = 1'b1;
   logic [2*LANES-1:0] lp_i    = 4'b1111;
   logic [LANES-1:0]   hs_burst_o, hs_start_o, hs_end_o, esc_entry_o, err_o;
   logic [4*LANES-1:0] state_o;
   logic               all_hs_o;

   logic [1:0] l0 = 2'b11;
   logic [1:0] l1 = 2'b11;

   int n_checks = 0;
   int n_errors = 0;
   int n_start  = 0;
   int n_end    = 0;
   int n_esc    = 0;
   int n_err    = 0;
   int snap;

   mipi_lp_lane_state_detector #(
      .LANES          (LANES),
      .SETTLE_CYCLES  (SETTLE),
      .GLITCH_CYCLES  (GLITCH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .lp_i        (lp_i),
      .hs_burst_o  (hs_burst_o),
      .hs_start_o  (hs_start_o),
      .hs_end_o    (hs_end_o),
      .esc_entry_o (esc_entry_o),
      .err_o       (err_o),
      .state_o     (state_o),
      .all_hs_o    (all_hs_o)
   );

   always #5 sys_clk = ~sys_clk;

   // lane-0 pulse tallies, sampled mid-cycle
   always @(negedge sys_clk) begin
      if (hs_start_o[0])  n_start++;
      if (hs_end_o[0])    n_end++;
      if (esc_entry_o[0]) n_esc++;
      if (err_o[0])       n_err++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic drive(input logic [1:0] a, input logic [1:0] b);
      l0 = a;
      l1 = b;
      lp_i = {l1, l0};
   endtask

   initial begin
      // reset state
      tick(3);
      check_eq("rst_state", 32'(state_o), 32'h0);
      check_eq("rst_outs", 32'({hs_burst_o, hs_start_o, hs_end_o, esc_entry_o, err_o, all_hs_o}), 32'h0);
      sys_rst = 1'b0;
      tick(8);
      check_eq("post_rst_state", 32'(state_o), 32'h0);
      check_eq("post_rst_err", 32'(n_err), 32'd0);

      // lane 0: HS entry and exit, lane 1 idle
      drive(2'b01, 2'b11);
      tick(10);
      check_eq("hs_rqst", 32'(state_o[3:0]), 32'd1);
      drive(2'b00, 2'b11);
      snap = n_start;
      tick(5);
      check_eq("hs_prpr_entry", 32'(state_o[3:0]), 32'd2);
      tick(3);
      check_eq("hs_prpr_last", 32'(state_o[3:0]), 32'd2);
      check_eq("no_burst_yet", 32'(hs_burst_o[0]), 32'd0);
      tick(1);
      check_eq("hs_burst_state", 32'(state_o[3:0]), 32'd3);
      check_eq("hs_start_pulse", 32'(hs_start_o[0]), 32'd1);
      check_eq("hs_burst_bit", 32'(hs_burst_o[0]), 32'd1);
      check_eq("lane1_stop", 32'(state_o[7:4]), 32'd0);
      check_eq("all_hs_lane1_idle", 32'(all_hs_o), 32'd0);
      tick(1);
      check_eq("hs_start_width", 32'(hs_start_o[0]), 32'd0);
      check_eq("hs_start_count", 32'(n_start - snap), 32'd1);
      drive(2'b11, 2'b11);
      snap = n_end;
      tick(4);
      check_eq("burst_hold", 32'(hs_burst_o[0]), 32'd1);
      tick(1);
      check_eq("hs_end_pulse", 32'(hs_end_o[0]), 32'd1);
      check_eq("stop_after_burst", 32'(state_o[3:0]), 32'd0);
      check_eq("burst_cleared", 32'(hs_burst_o[0]), 32'd0);
      tick(3);
      check_eq("hs_end_count", 32'(n_end - snap), 32'd1);

      // both lanes in HS, lane 1 two cycles behind
      drive(2'b01, 2'b11);
      tick(2);
      drive(2'b01, 2'b01);
      tick(8);
      drive(2'b00, 2'b01);
      tick(2);
      drive(2'b00, 2'b00);
      tick(7);
      check_eq("lane0_first_burst", 32'(hs_burst_o), 32'b01);
      check_eq("all_hs_lane0_only", 32'(all_hs_o), 32'd0);
      tick(1);
      check_eq("all_hs_still_low", 32'(all_hs_o), 32'd0);
      tick(1);
      check_eq("all_hs_rise", 32'(all_hs_o), 32'd1);
      tick(3);
      drive(2'b11, 2'b00);
      tick(4);
      check_eq("all_hs_hold", 32'(all_hs_o), 32'd1);
      tick(1);
      check_eq("all_hs_fall", 32'(all_hs_o), 32'd0);
      check_eq("lane1_still_burst", 32'(hs_burst_o[1]), 32'd1);
      drive(2'b11, 2'b11);
      tick(10);
      check_eq("both_stop", 32'(state_o), 32'h0);

      // escape entry
      snap = n_err;
      drive(2'b10, 2'b11);
      tick(10);
      check_eq("esc_rqst", 32'(state_o[3:0]), 32'd4);
      drive(2'b00, 2'b11);
      tick(10);
      check_eq("esc_go", 32'(state_o[3:0]), 32'd5);
      drive(2'b01, 2'b11);
      tick(10);
      check_eq("esc_conf", 32'(state_o[3:0]), 32'd6);
      drive(2'b00, 2'b11);
      tick(5);
      check_eq("esc_entry_pulse", 32'(esc_entry_o[0]), 32'd1);
      check_eq("esc_mode", 32'(state_o[3:0]), 32'd7);
      tick(5);
      check_eq("esc_entry_count", 32'(n_esc), 32'd1);
      drive(2'b11, 2'b11);
      tick(10);
      check_eq("esc_exit_stop", 32'(state_o[3:0]), 32'd0);
      check_eq("esc_no_err", 32'(n_err - snap), 32'd0);

      // STOP -> LP00 is illegal
      snap = n_err;
      drive(2'b00, 2'b11);
      tick(5);
      check_eq("err_state", 32'(state_o[3:0]), 32'd8);
      check_eq("err_pulse", 32'(err_o[0]), 32'd1);
      tick(20);
      check_eq("err_single", 32'(n_err - snap), 32'd1);
      drive(2'b11, 2'b11);
      tick(10);
      check_eq("err_exit_stop", 32'(state_o[3:0]), 32'd0);

      // one-cycle glitch, then HS_RQST timeout
      drive(2'b01, 2'b11);
      tick(1);
      drive(2'b11, 2'b11);
      tick(10);
      check_eq("glitch_rejected", 32'(state_o[3:0]), 32'd0);
      snap = n_err;
      drive(2'b01, 2'b11);
      tick(40);
      check_eq("rqst_before_timeout", 32'(state_o[3:0]), 32'd1);
      tick(40);
      check_eq("timeout_err", 32'(state_o[3:0]), 32'd8);
      check_eq("timeout_err_count", 32'(n_err - snap), 32'd1);
      drive(2'b11, 2'b11);
      tick(10);
      check_eq("timeout_exit_stop", 32'(state_o[3:0]), 32'd0);

      // asynchronous reset mid-burst
      drive(2'b01, 2'b11);
      tick(10);
      drive(2'b00, 2'b11);
      tick(12);
      check_eq("pre_rst_burst", 32'(hs_burst_o[0]), 32'd1);
      snap = n_end;
      #2;
      sys_rst = 1'b1;
      #1;
      check_eq("async_rst_burst", 32'(hs_burst_o[0]), 32'd0);
      check_eq("async_rst_state", 32'(state_o[3:0]), 32'd0);
      drive(2'b11, 2'b11);
      tick(3);
      sys_rst = 1'b0;
      tick(6);
      check_eq("rst_no_hs_end", 32'(n_end - snap), 32'd0);
      check_eq("rst_recover_stop", 32'(state_o), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
